// File: rtl/msrv32_param_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_param_reg_file_if
// Description : Read, writeback, issue and clear signals of the parametrised
//               msrv32 register file, bundled into a single bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface msrv32_param_reg_file_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs_1_addr_in;
    logic [AW-1:0]   rs_2_addr_in;
    logic [XLEN-1:0] rs_1_out;
    logic [XLEN-1:0] rs_2_out;
    logic            wr_en_in;
    logic [AW-1:0]   rd_addr_in;
    logic [XLEN-1:0] rd_in;
    logic            issue_en_in;
    logic [AW-1:0]   issue_rd_addr_in;
    logic            rs_1_busy_out;
    logic            rs_2_busy_out;
    logic            clr_req_in;
    logic            clr_busy_out;

    // Pipeline side: decode/issue and writeback.
    modport master (
        output rs_1_addr_in, rs_2_addr_in, wr_en_in, rd_addr_in, rd_in,
               issue_en_in, issue_rd_addr_in, clr_req_in,
        input  rs_1_out, rs_2_out, rs_1_busy_out, rs_2_busy_out, clr_busy_out
    );

    // Register file side.
    modport slave (
        input  rs_1_addr_in, rs_2_addr_in, wr_en_in, rd_addr_in, rd_in,
               issue_en_in, issue_rd_addr_in, clr_req_in,
        output rs_1_out, rs_2_out, rs_1_busy_out, rs_2_busy_out, clr_busy_out
    );
endinterface
`default_nettype wire

// File: rtl/msrv32_param_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_param_reg_file
// Description : XLEN x NREGS register file, 2 async read / 1 sync write, x0
//               hardwired to zero, per-register busy scoreboard and a
//               one-entry-per-cycle clear engine. Optional write-through
//               forwarding is enabled by defining MSRV32_RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_param_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  wire logic               ms_riscv32_mp_clk_in,
    input  wire logic               ms_riscv32_mp_rst_in,
    msrv32_param_reg_file_if.slave  rf_bus
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] c_FIRST  = AW'(1);
    localparam logic [AW-1:0] c_LAST   = AW'(NREGS - 1);
    localparam logic [AW-1:0] c_ZERO   = '0;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;

    logic             w_idle;
    logic             w_wr_fire;
    logic             w_iss_fire;
    logic             w_clr_start;

    assign w_idle      = (state_q == ST_IDLE);
    assign w_wr_fire   = w_idle && rf_bus.wr_en_in    && (rf_bus.rd_addr_in != c_ZERO);
    assign w_iss_fire  = w_idle && rf_bus.issue_en_in && (rf_bus.issue_rd_addr_in != c_ZERO);
    assign w_clr_start = w_idle && rf_bus.clr_req_in;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (rf_bus.clr_req_in) begin
                    state_d = ST_CLEAR;
                    idx_d   = c_FIRST;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + c_FIRST;
                if (idx_q == c_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q <= ST_IDLE;
            idx_q   <= c_FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Later assignments win: a new producer keeps busy set over a same-cycle
    // writeback, and entering CLEAR drops every reservation.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (w_wr_fire) begin
                regs_q[rf_bus.rd_addr_in] <= rf_bus.rd_in;
                busy_q[rf_bus.rd_addr_in] <= 1'b0;
            end
            if (w_iss_fire) begin
                busy_q[rf_bus.issue_rd_addr_in] <= 1'b1;
            end
            if (w_clr_start) begin
                busy_q <= '0;
            end
            if (state_q == ST_CLEAR) begin
                regs_q[idx_q] <= '0;
            end
        end
    end

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_rs1_busy;
    logic            w_rs2_busy;

    always_comb begin
        w_rs1_data = (rf_bus.rs_1_addr_in == c_ZERO) ? '0 : regs_q[rf_bus.rs_1_addr_in];
        w_rs2_data = (rf_bus.rs_2_addr_in == c_ZERO) ? '0 : regs_q[rf_bus.rs_2_addr_in];
        w_rs1_busy = (rf_bus.rs_1_addr_in == c_ZERO) ? 1'b0 : busy_q[rf_bus.rs_1_addr_in];
        w_rs2_busy = (rf_bus.rs_2_addr_in == c_ZERO) ? 1'b0 : busy_q[rf_bus.rs_2_addr_in];
`ifdef MSRV32_RF_BYPASS_EN
        // w_wr_fire already excludes x0, so x0 can never be forwarded.
        if (w_wr_fire && (rf_bus.rd_addr_in == rf_bus.rs_1_addr_in)) begin
            w_rs1_data = rf_bus.rd_in;
            w_rs1_busy = 1'b0;
        end
        if (w_wr_fire && (rf_bus.rd_addr_in == rf_bus.rs_2_addr_in)) begin
            w_rs2_data = rf_bus.rd_in;
            w_rs2_busy = 1'b0;
        end
`else
        w_rs1_data = w_rs1_data;
        w_rs2_data = w_rs2_data;
`endif
    end

    assign rf_bus.rs_1_out      = w_rs1_data;
    assign rf_bus.rs_2_out      = w_rs2_data;
    assign rf_bus.rs_1_busy_out = w_rs1_busy;
    assign rf_bus.rs_2_busy_out = w_rs2_busy;
    assign rf_bus.clr_busy_out  = (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_msrv32_param_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrv32_param_reg_file
// Description : Directed scoreboard bench for msrv32_param_reg_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_param_reg_file;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
`ifdef MSRV32_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msrv32_param_reg_file_if #(.XLEN(XLEN), .AW(AW)) bus ();

    msrv32_param_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .rf_bus               (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        cb;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", n, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from state changes.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp({e.name, ".rs1"},   bus.rs_1_out, e.d1);
            cmp({e.name, ".rs2"},   bus.rs_2_out, e.d2);
            cmp({e.name, ".busy1"}, {31'd0, bus.rs_1_busy_out}, {31'd0, e.b1});
            cmp({e.name, ".busy2"}, {31'd0, bus.rs_2_busy_out}, {31'd0, e.b2});
            cmp({e.name, ".clrb"},  {31'd0, bus.clr_busy_out},  {31'd0, e.cb});
        end
    end

    task automatic expect_rd(input string n, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic b1, input logic b2, input logic cb);
        exp_t e;
        bus.rs_1_addr_in = a1;
        bus.rs_2_addr_in = a2;
        e.name = n; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.cb = cb;
        q.push_back(e);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en_in   = 1'b1;
        bus.rd_addr_in = a;
        bus.rd_in      = d;
        @(posedge clk); #1;
        bus.wr_en_in   = 1'b0;
    endtask

    task automatic issue_reg(input logic [4:0] a);
        bus.issue_en_in      = 1'b1;
        bus.issue_rd_addr_in = a;
        @(posedge clk); #1;
        bus.issue_en_in      = 1'b0;
    endtask

    initial begin
        logic [31:0] e1;
        logic [31:0] e2;
        int          n;
        bus.rs_1_addr_in = '0; bus.rs_2_addr_in = '0;
        bus.wr_en_in = 1'b0; bus.rd_addr_in = '0; bus.rd_in = '0;
        bus.issue_en_in = 1'b0; bus.issue_rd_addr_in = '0; bus.clr_req_in = 1'b0;

        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_rd("reset", 5'd1, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        write_reg(5'd1, 32'h12345678);
        write_reg(5'd0, 32'hAABBCCDD);
        expect_rd("wr_x1_x0", 5'd1, 5'd0, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0);

        issue_reg(5'd5);
        issue_reg(5'd0);
        expect_rd("issue_x5", 5'd5, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        write_reg(5'd5, 32'hDEADBEEF);
        expect_rd("wb_x5", 5'd1, 5'd5, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);

        bus.issue_en_in = 1'b1; bus.issue_rd_addr_in = 5'd7;
        write_reg(5'd7, 32'h00000077);
        bus.issue_en_in = 1'b0;
        expect_rd("iss_wr_x7", 5'd7, 5'd5, 32'h77, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);

        issue_reg(5'd3);
        bus.wr_en_in = 1'b1; bus.rd_addr_in = 5'd3; bus.rd_in = 32'hCAFEF00D;
        expect_rd("bypass", 5'd3, 5'd1, BYP ? 32'hCAFEF00D : 32'h0, 32'h12345678,
                  BYP ? 1'b0 : 1'b1, 1'b0, 1'b0);
        bus.wr_en_in = 1'b0;
        expect_rd("bypass_after", 5'd3, 5'd0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0);

        // Full clear: preload xi = i, reserve x9, clear request coincides with a write.
        for (int i = 1; i < NREGS; i++) write_reg(5'(i), 32'(i));
        issue_reg(5'd9);
        expect_rd("pre_clear", 5'd9, 5'd31, 32'd9, 32'd31, 1'b1, 1'b0, 1'b0);
        bus.clr_req_in = 1'b1;
        write_reg(5'd1, 32'h111);
        bus.clr_req_in = 1'b0;
        for (int k = 0; k < 32; k++) begin
            bus.wr_en_in         = (k < 31);
            bus.rd_addr_in       = 5'd2;
            bus.rd_in            = 32'hFFFFFFFF;
            bus.issue_en_in      = (k < 31);
            bus.issue_rd_addr_in = 5'd31;
            bus.clr_req_in       = (k == 5);
            e1 = (k == 0) ? 32'h111 : ((k < 2) ? 32'd2 : 32'd0);
            e2 = (k < 31) ? 32'd31 : 32'd0;
            expect_rd($sformatf("clear_k%0d", k), (k == 0) ? 5'd1 : 5'd2, 5'd31,
                      e1, e2, 1'b0, 1'b0, (k < 31));
        end
        bus.wr_en_in = 1'b0; bus.issue_en_in = 1'b0; bus.clr_req_in = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            expect_rd($sformatf("post_clear_%0d", i), 5'(i), 5'(32 - i),
                      32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end

        // Reset ten cycles into a clear.
        write_reg(5'd20, 32'h55);
        write_reg(5'd31, 32'h31);
        bus.clr_req_in = 1'b1;
        @(posedge clk); #1;
        bus.clr_req_in = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_rd("rst_mid", 5'd20, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_rd("rst_mid_idle", 5'd9, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        write_reg(5'd4, 32'h44);
        expect_rd("wr_after_rst", 5'd4, 5'd20, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0);

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
